inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Fetch stage with an instruction prefetch queue. It sits between the instruction memory and the decode stage.
- It issues word-addressed fetch requests to memory using a req/ack handshake with at most one request outstanding. Returned instructions are buffered with their PC in a first-word-fall-through (FWFT) FIFO.
- The FIFO presents instructions to decode via valid/ready.
- A redirect input (branch/jump) flushes the queue and restarts fetch at a new PC.

Parameters:
- PC_W, 12, PC / instruction address width.
- INST_W, 16, instruction width.
- DEPTH, 4, FIFO entries (power of two, >=2).
- RESET_PC, 0, fetch PC after reset.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- o_mem_req  output  1  fetch request to instruction memory.
- o_mem_addr  output  PC_W  fetch address; stable while o_mem_req=1.
- i_mem_ack  input  1  memory accepts the request and returns data this cycle; ignored when o_mem_req=0.
- i_mem_rdata  input  INST_W  instruction data; valid when o_mem_req & i_mem_ack.
- o_inst_valid  output  1  FIFO head valid.
- o_instruction  output  INST_W  FIFO head instruction.
- o_inst_pc  output  PC_W  PC of the FIFO head.
- i_inst_ready  input  1  decode consumes the head when o_inst_valid & i_inst_ready.
- i_redirect  input  1  flush and restart fetch.
- i_redirect_pc  input  PC_W  new fetch PC; sampled when i_redirect=1.
- o_pc  output  PC_W  next PC to be fetched (fetch pointer).
- o_count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (i_reset=0, asynchronous): the following take these values immediately.
  - o_mem_req=0, o_mem_addr=RESET_PC, o_pc=RESET_PC.
  - FIFO empty: o_count=0, o_inst_valid=0, o_instruction=0, o_inst_pc=0.
  - FSM=IDLE.
- Reset asserted mid-request: the outstanding request is abandoned. The memory must also be reset.
- FSM states: IDLE, REQ, DROP. o_mem_req=1 in REQ and DROP; o_mem_req is registered.
- IDLE -> REQ:
  - Condition: !i_redirect and (o_count - pops_this_cycle) < DEPTH.
  - Action: o_mem_addr<=o_pc.
  - Timing: the first request is visible on the first cycle after the first rising edge following reset release.
- REQ, i_mem_ack=1, no redirect:
  - Push {i_mem_rdata, o_mem_addr} into the FIFO.
  - o_pc <= o_pc+1, wrapping modulo 2^PC_W (0xFFF -> 0x000).
  - If space remains after this push, net of the pop this cycle: stay in REQ with o_mem_addr <= o_pc+1 (back-to-back, one fetch per cycle).
  - Otherwise go to IDLE.
- REQ, i_mem_ack=0, no redirect: hold o_mem_req and o_mem_addr.
- Redirect handling:
  - i_redirect=1 in any state: FIFO flushed (o_count=0 next cycle), o_pc <= i_redirect_pc.
  - Redirect in REQ with i_mem_ack=0: go to DROP. Request and address stay stable until ack, because the memory protocol forbids withdrawing a request.
  - Redirect in REQ with i_mem_ack=1 in the same cycle: returned data discarded, go to IDLE.
  - Redirect in IDLE: stay in IDLE.
- DROP:
  - On ack: discard data, go to IDLE.
  - A second redirect while in DROP updates o_pc again and stays in DROP.
- Space rule: a request is issued only when a FIFO slot is free at its return. Overflow is therefore impossible; the bench asserts no push while full.
- FIFO:
  - FWFT: o_inst_valid = (o_count != 0); o_instruction and o_inst_pc show the head combinationally from storage.
  - Push and pop in the same cycle: both happen, count unchanged.
  - Pop when empty: no effect.
  - Read/write pointers wrap modulo DEPTH.
  - Flush resets both pointers and the count.
- Redirect and pop in the same cycle: the popped head counts as consumed by decode; the remaining entries are flushed.
- Latency:
  - Memory ack to o_inst_valid: 1 cycle.
  - Redirect to first request at the new PC: 1 cycle from IDLE/REQ; from DROP, 1 cycle after the dropped ack.

Test Plan:
- Reset release, memory acks every cycle, i_inst_ready=1 -> requests to 0x000, 0x001, 0x002…, one per cycle; o_inst_pc follows 1 cycle after each ack; instructions delivered in order.
- i_inst_ready=0, zero-latency memory -> exactly 4 entries (PCs 0x000-0x003), o_count=4, o_mem_req=0 afterward; ready=1 for one cycle -> exactly one new request (0x004).
- Memory ack delayed 3 cycles -> o_mem_req and o_mem_addr held stable for all 3 cycles; a single push on ack.
- Redirect to 0x120 while a request to 0x005 is pending unacked -> FSM in DROP, 0x005 data discarded on ack, next request addr 0x120, FIFO empty until then.
- Redirect to 0x200 in the same cycle as an ack and a pop -> FIFO empty next cycle, acked data discarded, next request 0x200.
- Redirect to 0xFFE, free-running fetch -> addresses 0xFFE, 0xFFF, 0x000; then i_reset pulsed low mid-request -> o_mem_req=0 and o_inst_valid=0 immediately, o_pc=RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: fetch stage issuing one outstanding req/ack memory fetch into an FWFT prefetch FIFO feeding decode.
module inst_fetch_queue #(
    parameter int              PC_W     = 12,
    parameter int              INST_W   = 16,
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    output logic                     o_mem_req,
    output logic [PC_W-1:0]          o_mem_addr,
    input  logic                     i_mem_ack,
    input  logic [INST_W-1:0]        i_mem_rdata,
    output logic                     o_inst_valid,
    output logic [INST_W-1:0]        o_instruction,
    output logic [PC_W-1:0]          o_inst_pc,
    input  logic                     i_inst_ready,
    input  logic                     i_redirect,
    input  logic [PC_W-1:0]          i_redirect_pc,
    output logic [PC_W-1:0]          o_pc,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] DROP = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [PC_W-1:0]   addr_nxt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     cnt_nxt;
    logic              push, pop, space;
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem [DEPTH];

    assign pop           = o_inst_valid & i_inst_ready;
    assign push          = (state == REQ) & i_mem_ack & ~i_redirect;
    assign cnt_nxt       = o_count + CW'(push) - CW'(pop);
    // A request is only launched if its data is guaranteed a free slot on return.
    assign space         = cnt_nxt < FULL;
    assign o_mem_req     = state != IDLE;
    assign o_inst_valid  = o_count != '0;
    assign o_instruction = inst_mem[rd_ptr];
    assign o_inst_pc     = pc_mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        addr_nxt  = o_mem_addr;
        if (state == IDLE) begin
            if (!i_redirect && space) begin
                state_nxt = REQ;
                addr_nxt  = o_pc;
            end
        end else if (state == REQ) begin
            if (i_redirect) begin
                state_nxt = i_mem_ack ? IDLE : DROP;
            end else if (i_mem_ack) begin
                state_nxt = space ? REQ : IDLE;
                addr_nxt  = space ? o_pc + PC_W'(1) : o_mem_addr;
            end
        end else begin
            // A request cannot be withdrawn: wait out the stale ack before refetching.
            state_nxt = i_mem_ack ? IDLE : state;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state      <= IDLE;
            o_mem_addr <= RESET_PC;
            o_pc       <= RESET_PC;
            o_count    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            state      <= state_nxt;
            o_mem_addr <= addr_nxt;
            o_pc       <= i_redirect ? i_redirect_pc : push ? o_pc + PC_W'(1) : o_pc;
            o_count    <= i_redirect ? '0 : cnt_nxt;
            wr_ptr     <= i_redirect ? '0 : push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr     <= i_redirect ? '0 : pop ? rd_ptr + AW'(1) : rd_ptr;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                inst_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (push) begin
            inst_mem[wr_ptr] <= i_mem_rdata;
            pc_mem[wr_ptr]   <= o_mem_addr;
        end
    end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed checks of fetch handshake, FIFO fill/drain, redirect/drop and async reset.
module tb_inst_fetch_queue;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        o_mem_req;
    logic [11:0] o_mem_addr;
    logic        i_mem_ack;
    logic [15:0] i_mem_rdata;
    logic        o_inst_valid;
    logic [15:0] o_instruction;
    logic [11:0] o_inst_pc;
    logic        i_inst_ready;
    logic        i_redirect;
    logic [11:0] i_redirect_pc;
    logic [11:0] o_pc;
    logic [2:0]  o_count;
    int          passed = 0;
    int          total  = 0;
    logic        overflow = 1'b0;

    inst_fetch_queue dut (
        .i_clk(i_clk), .i_reset(i_reset), .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_inst_valid(o_inst_valid),
        .o_instruction(o_instruction), .o_inst_pc(o_inst_pc), .i_inst_ready(i_inst_ready),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .o_pc(o_pc), .o_count(o_count)
    );

    always #5 i_clk = ~i_clk;

    // Memory returns a recognisable word tagged with its address.
    assign i_mem_rdata = {4'hA, o_mem_addr};

    always @(negedge i_clk)
        if (i_reset && o_mem_req && i_mem_ack && !i_redirect && o_count == 3'd4 && !(o_inst_valid && i_inst_ready))
            overflow = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset = 1'b0; i_mem_ack = 1'b0; i_inst_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        #1;
        check("rst_req", o_mem_req, 0);
        check("rst_addr", o_mem_addr, 0);
        check("rst_pc", o_pc, 0);
        check("rst_count", o_count, 0);
        check("rst_valid", o_inst_valid, 0);
        check("rst_inst", o_instruction, 0);
        check("rst_inst_pc", o_inst_pc, 0);
        tick();
        i_reset = 1'b1; i_mem_ack = 1'b1; i_inst_ready = 1'b1;
        tick();
        check("t1_req0", o_mem_req, 1);
        check("t1_addr0", o_mem_addr, 12'h000);
        tick();
        check("t1_addr1", o_mem_addr, 12'h001);
        check("t1_valid", o_inst_valid, 1);
        check("t1_ipc0", o_inst_pc, 12'h000);
        check("t1_inst0", o_instruction, 16'hA000);
        tick();
        check("t1_addr2", o_mem_addr, 12'h002);
        check("t1_ipc1", o_inst_pc, 12'h001);
        check("t1_cnt", o_count, 1);
        tick();
        check("t1_addr3", o_mem_addr, 12'h003);
        check("t1_ipc2", o_inst_pc, 12'h002);
        check("t1_inst2", o_instruction, 16'hA002);
        // Fill with decode stalled, starting from a fresh reset.
        i_inst_ready = 1'b0; i_reset = 1'b0;
        #2;
        i_reset = 1'b1;
        tick();
        check("t2_addr0", o_mem_addr, 12'h000);
        tick(); tick(); tick(); tick();
        check("t2_full_cnt", o_count, 4);
        check("t2_full_req", o_mem_req, 0);
        check("t2_full_pc", o_pc, 12'h004);
        check("t2_head_pc", o_inst_pc, 12'h000);
        tick();
        check("t2_idle_req", o_mem_req, 0);
        check("t2_idle_cnt", o_count, 4);
        i_inst_ready = 1'b1;
        tick();
        check("t2_one_req", o_mem_req, 1);
        check("t2_one_addr", o_mem_addr, 12'h004);
        check("t2_pop_cnt", o_count, 3);
        check("t2_pop_head", o_inst_pc, 12'h001);
        // Hold the 0x004 ack off for three edges.
        i_inst_ready = 1'b0; i_mem_ack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t3_hold_req", o_mem_req, 1);
            check("t3_hold_addr", o_mem_addr, 12'h004);
            check("t3_hold_cnt", o_count, 3);
        end
        i_mem_ack = 1'b1;
        tick();
        check("t3_push_cnt", o_count, 4);
        check("t3_push_req", o_mem_req, 0);
        check("t3_push_pc", o_pc, 12'h005);
        tick();
        check("t3_single_req", o_mem_req, 0);
        // Redirect while 0x005 is outstanding.
        i_inst_ready = 1'b1; i_mem_ack = 1'b0;
        tick();
        check("t4_req5", o_mem_addr, 12'h005);
        i_inst_ready = 1'b0; i_redirect = 1'b1; i_redirect_pc = 12'h120;
        tick();
        check("t4_drop_req", o_mem_req, 1);
        check("t4_drop_addr", o_mem_addr, 12'h005);
        check("t4_flush_cnt", o_count, 0);
        check("t4_flush_valid", o_inst_valid, 0);
        check("t4_new_pc", o_pc, 12'h120);
        i_redirect = 1'b0;
        tick();
        check("t4_drop_hold", o_mem_addr, 12'h005);
        i_mem_ack = 1'b1;
        tick();
        check("t4_drop_done_req", o_mem_req, 0);
        check("t4_drop_discard", o_count, 0);
        tick();
        check("t4_refetch_addr", o_mem_addr, 12'h120);
        check("t4_refetch_empty", o_inst_valid, 0);
        tick();
        check("t4_head_pc", o_inst_pc, 12'h120);
        check("t4_head_inst", o_instruction, 16'hA120);
        check("t4_cnt", o_count, 1);
        // Redirect coinciding with an ack and a pop.
        i_inst_ready = 1'b1; i_redirect = 1'b1; i_redirect_pc = 12'h200;
        tick();
        check("t5_flush_cnt", o_count, 0);
        check("t5_flush_valid", o_inst_valid, 0);
        check("t5_idle_req", o_mem_req, 0);
        check("t5_pc", o_pc, 12'h200);
        i_redirect = 1'b0;
        tick();
        check("t5_addr", o_mem_addr, 12'h200);
        tick();
        check("t5_head_pc", o_inst_pc, 12'h200);
        // PC wrap at the top of the address space.
        i_redirect = 1'b1; i_redirect_pc = 12'hFFE;
        tick();
        check("t6_pc", o_pc, 12'hFFE);
        i_redirect = 1'b0;
        tick();
        check("t6_addr_ffe", o_mem_addr, 12'hFFE);
        tick();
        check("t6_addr_fff", o_mem_addr, 12'hFFF);
        check("t6_ipc_ffe", o_inst_pc, 12'hFFE);
        tick();
        check("t6_addr_000", o_mem_addr, 12'h000);
        check("t6_ipc_fff", o_inst_pc, 12'hFFF);
        check("t6_pc_wrap", o_pc, 12'h000);
        tick();
        check("t6_pc_001", o_pc, 12'h001);
        // Asynchronous reset while a request is live.
        i_reset = 1'b0;
        #1;
        check("t6_arst_req", o_mem_req, 0);
        check("t6_arst_valid", o_inst_valid, 0);
        check("t6_arst_pc", o_pc, 12'h000);
        check("t6_arst_cnt", o_count, 0);
        i_reset = 1'b1;
        tick();
        check("t6_restart_req", o_mem_req, 1);
        check("t6_restart_addr", o_mem_addr, 12'h000);
        check("no_push_full", overflow, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
